// File: rtl/apb_master.sv
// APB master: takes a single request, decodes it to one of four slaves in a
// 16 KiB window above BASE_ADDR, runs the SETUP/ACCESS handshake and returns
// a one-cycle ready pulse with read data and an error flag. Requests outside
// the window or slaves that never answer complete with slverr=1.
//
// state  | meaning
// IDLE   | waiting for transfer; also the cycle carrying the ready pulse
// SETUP  | PSEL asserted, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high until PREADY, miss, or wait timeout
module apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        slverr,
  output logic [11:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  output logic        PENABLE,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [1:0]  idx;
  logic        miss;
  logic [7:0]  wait_cnt;
  logic [3:0]  psel;
  logic        hit;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  assign PSEL0 = psel[0];
  assign PSEL1 = psel[1];
  assign PSEL2 = psel[2];
  assign PSEL3 = psel[3];

  // Window decode of the incoming request address.
  assign hit = (addr[31:14] == BASE_ADDR[31:14]);

  // Only the selected slave's PREADY/PRDATA are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    case (idx)
      2'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
      2'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
      2'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
      default: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
    endcase
  end

  // Transfer sequencer with all bus and completion outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      idx      <= 2'd0;
      miss     <= 1'b0;
      wait_cnt <= 8'd0;
      psel     <= 4'b0000;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= 12'h000;
      PWDATA   <= 32'h0;
      rdata    <= 32'h0;
      ready    <= 1'b0;
      slverr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready  <= 1'b0;
          slverr <= 1'b0;
          rdata  <= 32'h0;
          if (transfer) begin
            PADDR  <= addr[11:0];
            PWRITE <= write;
            PWDATA <= wdata;
            idx    <= addr[13:12];
            miss   <= ~hit;
            psel   <= hit ? (4'b0001 << addr[13:12]) : 4'b0000;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A PREADY on the timeout cycle still wins over the timeout.
          if (miss || sel_ready || (wait_cnt == TIMEOUT_CNT)) begin
            state   <= IDLE;
            psel    <= 4'b0000;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            if (!miss && sel_ready) begin
              slverr <= 1'b0;
              rdata  <= PWRITE ? 32'h0 : sel_rdata;
            end else begin
              slverr <= 1'b1;
              rdata  <= 32'h0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: base of the 16 KiB peripheral window.
REQ-002 Parameter TIMEOUT, default 255: maximum ACCESS-phase cycles waiting for PREADY, range 1..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high (PCLK, PRESET).
REQ-004 PCLK  in  1  clock; all state updates on its rising edge.
REQ-005 PRESET  in  1  synchronous active-high reset.
REQ-006 transfer  in  1  request; sampled only in IDLE.
REQ-007 write  in  1  1=write, 0=read; sampled with transfer.
REQ-008 addr  in  32  byte address; sampled with transfer.
REQ-009 wdata  in  32  write data; sampled with transfer.
REQ-010 rdata  out  32  read data; valid while ready=1.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 slverr  out  1  error flag; valid while ready=1.
REQ-013 PADDR  out  12  addr[11:0] of the latched request.
REQ-014 PWRITE / PWDATA  out  1 / 32  latched write flag and data.
REQ-015 PSEL0..PSEL3  out  1 each  one-hot slave select.
REQ-016 PENABLE  out  1  APB access-phase strobe.
REQ-017 PRDATA0..3 / PREADY0..3  in  32 / 1 each  per-slave read data and ready.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-019 In IDLE with transfer=1, the block SHALL latch write, addr and wdata, then go to SETUP; transfer=0 stays IDLE.
REQ-020 Decode SHALL be idx=addr[13:12] when addr[31:14]==BASE_ADDR[31:14]; otherwise the request is a miss.
REQ-021 SETUP lasts exactly one cycle: PSEL[idx]=1, PENABLE=0, other PSELs=0. Next state is ACCESS.
REQ-022 ACCESS: PSEL[idx]=1, PENABLE=1; PADDR, PWRITE and PWDATA held stable until exit.
REQ-023 ACCESS exits when PREADY[idx]=1; selected PREADY/PRDATA come from a mux on idx, and unselected PREADYs are ignored.
REQ-024 On exit, the next cycle SHALL have state IDLE, PSEL=0, PENABLE=0 and ready=1 for exactly one cycle.
REQ-025 On a read, rdata SHALL equal PRDATA[idx] sampled on the exit edge; on a write, rdata=0.
REQ-026 A miss SHALL assert no PSEL, spend one cycle in SETUP and one in ACCESS, then exit with slverr=1 and rdata=0.
REQ-027 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without PREADY.
REQ-028 When the counter reaches TIMEOUT, ACCESS SHALL exit with slverr=1 and rdata=0.
REQ-029 PREADY arriving on the same edge the timeout hits SHALL count as success (slverr=0).
REQ-030 transfer SHALL be ignored outside IDLE; in the ready cycle the state is IDLE, so a held transfer starts the next request there.
REQ-031 Back-to-back requests: minimum period 3 cycles with a zero-wait slave, 4 cycles with the registered-PREADY RAM.
REQ-032 Timing: transfer sampled at edge N → SETUP in cycle N+1, ACCESS from N+2. PREADY at cycle k → ready at k+1.

Reset
REQ-033 PRESET=1 at an edge SHALL force IDLE and clear state regardless of phase, including mid-ACCESS.
REQ-034 Reset values: all PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, slverr=0, counter=0.
REQ-035 A transfer asserted in the same cycle as PRESET SHALL be dropped.

Verification
REQ-036 Write addr=0x1000_0004, wdata=0xDEADBEEF, RAM on slave 0 → PSEL0 for 2 ACCESS cycles, PADDR=0x004, ready at N+4, slverr=0.
REQ-037 Read back 0x1000_0004 → rdata=0xDEADBEEF, ready at N+4, PSEL1..3 never asserted.
REQ-038 Read addr=0x2000_0000 (miss) → no PSEL, ready at N+3, slverr=1, rdata=0.
REQ-039 Slave 2 holds PREADY2=0, TIMEOUT=4 → ready 5 cycles after ACCESS entry, slverr=1; then a write to slave 0 succeeds.
REQ-040 PRESET during ACCESS of a write to 0x1000_0008 → PSEL0=PENABLE=0 next cycle, no ready pulse, RAM word at 0x008 unchanged.
REQ-041 transfer held high for 10 cycles with a zero-wait slave → ready at N+3, N+6, N+9; PENABLE never high in SETUP cycles.
